// File: rtl/pong_pkg.sv
// Shared geometry, colours and FSM encodings for the Pong pixel engine.
// All coordinates are 10-bit unsigned screen positions.
package pong_pkg;

  typedef logic [11:0] rgb_t;

  localparam logic [9:0] SCREEN_X_MAX = 10'd639;
  localparam logic [9:0] SCREEN_Y_MAX = 10'd479;
  localparam logic [9:0] FRAME_TICK_Y = 10'd481;

  localparam logic [9:0] WALL_X_L     = 10'd32;
  localparam logic [9:0] WALL_X_R     = 10'd35;
  localparam logic [9:0] PAD_X_L      = 10'd600;
  localparam logic [9:0] PAD_X_R      = 10'd603;
  localparam logic [9:0] PAD_Y_RESET  = 10'd204;

  localparam logic [9:0] BALL_LAST    = 10'd7;
  localparam logic [9:0] BALL_X_PARK  = 10'd320;
  localparam logic [9:0] BALL_Y_PARK  = 10'd240;
  // Ball counts as gone once its right edge would leave the visible area.
  localparam logic [9:0] MISS_X       = SCREEN_X_MAX - BALL_LAST;

  localparam rgb_t COLOR_OFF    = 12'h000;
  localparam rgb_t COLOR_BALL   = 12'hF00;
  localparam rgb_t COLOR_PADDLE = 12'h0F0;
  localparam rgb_t COLOR_WALL   = 12'h00F;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_MISS = 2'd2;

  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// Paddle vertical position: moves once per frame from the button levels,
// clamped so the whole paddle stays inside rows 0..479.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PAD_V = 4,
  parameter int PAD_H = 72
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic [9:0] o_paddle_y
);

  localparam logic [9:0] C_V     = 10'(PAD_V);
  localparam logic [9:0] C_PH1   = 10'(PAD_H - 1);
  localparam logic [9:0] C_BOT_Y = SCREEN_Y_MAX - C_PH1;

  logic [9:0] r_paddle_y;
  logic [9:0] w_next_y;

  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_y unassigned (no latch).
    w_next_y = r_paddle_y;
    if (i_btn_up && !i_btn_down) begin
      w_next_y = (r_paddle_y >= C_V) ? r_paddle_y - C_V : '0;
    end else if (i_btn_down && !i_btn_up) begin
      w_next_y = (r_paddle_y + C_PH1 + C_V <= SCREEN_Y_MAX) ? r_paddle_y + C_V : C_BOT_Y;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_paddle_y <= PAD_Y_RESET;
    end else if (i_frame_tick) begin
      r_paddle_y <= w_next_y;
    end
  end

  assign o_paddle_y = r_paddle_y;

endmodule

// File: rtl/pong_graphics_engine.sv
// One-player Pong pixel stage: game state updated once per frame, and a
// one-pixel registered RGB/sync pipe kept aligned with the timing generator.
module pong_graphics_engine
  import pong_pkg::*;
#(
  parameter int BALL_V    = 2,
  parameter int PAD_V     = 4,
  parameter int PAD_H     = 72,
  parameter int MISS_HOLD = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_start,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hit,
  output logic        miss
);

  localparam logic [9:0] C_BV    = 10'(BALL_V);
  localparam logic [9:0] C_PH1   = 10'(PAD_H - 1);
  localparam logic [9:0] C_LEFT  = WALL_X_R + C_BV;
  localparam logic [9:0] C_BOT   = SCREEN_Y_MAX - C_BV;
  localparam int         CNT_W   = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MISS_HOLD - 1);

  logic [1:0]       r_state;
  logic [9:0]       r_ball_x, r_ball_y;
  logic             r_dx_neg, r_dy_neg;
  logic [CNT_W-1:0] r_miss_cnt;
  logic             r_hit, r_miss;
  rgb_t             r_rgb;
  logic             r_hsync, r_vsync;

  logic       w_frame_tick;
  logic [9:0] w_paddle_y;
  logic [9:0] w_ball_r, w_ball_b;
  logic       w_hit_top, w_hit_bot, w_hit_wall, w_hit_pad, w_exit;
  logic       w_dx_neg, w_dy_neg;
  logic       w_in_ball, w_in_pad, w_in_wall;
  rgb_t       w_color;

  assign w_frame_tick = pixel_tick && (pixel_x == '0) && (pixel_y == FRAME_TICK_Y);

  pong_paddle_ctrl #(
    .PAD_V (PAD_V),
    .PAD_H (PAD_H)
  ) u_paddle (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_frame_tick (w_frame_tick),
    .i_btn_up     (btn_up),
    .i_btn_down   (btn_down),
    .o_paddle_y   (w_paddle_y)
  );

  // Collisions look at the current position and the paddle before its own update.
  assign w_ball_r   = r_ball_x + BALL_LAST;
  assign w_ball_b   = r_ball_y + BALL_LAST;
  assign w_hit_top  = r_ball_y <= C_BV;
  assign w_hit_bot  = w_ball_b >= C_BOT;
  assign w_hit_wall = r_ball_x <= C_LEFT;
  assign w_hit_pad  = in_span(w_ball_r, PAD_X_L, PAD_X_R) &&
                      (w_ball_b >= w_paddle_y) && (r_ball_y <= w_paddle_y + C_PH1);
  assign w_exit     = r_ball_x >= MISS_X;

  assign w_dx_neg = w_hit_wall ? 1'b0 : (w_hit_pad ? 1'b1 : r_dx_neg);
  assign w_dy_neg = w_hit_top  ? 1'b0 : (w_hit_bot ? 1'b1 : r_dy_neg);

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous -- it only takes effect on a clock edge and overrides every event.
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ball_x   <= BALL_X_PARK;
      r_ball_y   <= BALL_Y_PARK;
      r_dx_neg   <= 1'b1;
      r_dy_neg   <= 1'b0;
      r_miss_cnt <= '0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (w_frame_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (btn_start) r_state <= ST_PLAY;
          end
          ST_PLAY: begin
            if (w_exit) begin
              r_miss     <= 1'b1;
              r_state    <= ST_MISS;
              r_miss_cnt <= '0;
            end else begin
              r_dx_neg <= w_dx_neg;
              r_dy_neg <= w_dy_neg;
              r_ball_x <= w_dx_neg ? r_ball_x - C_BV : r_ball_x + C_BV;
              r_ball_y <= w_dy_neg ? r_ball_y - C_BV : r_ball_y + C_BV;
              r_hit    <= w_hit_pad;
            end
          end
          ST_MISS: begin
            if (r_miss_cnt == C_HOLD_LAST) begin
              r_state    <= ST_IDLE;
              r_ball_x   <= BALL_X_PARK;
              r_ball_y   <= BALL_Y_PARK;
              r_dx_neg   <= 1'b1;
              r_miss_cnt <= '0;
            end else begin
              r_miss_cnt <= r_miss_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_in_ball = (r_state != ST_MISS) && in_span(pixel_x, r_ball_x, w_ball_r) &&
                     in_span(pixel_y, r_ball_y, w_ball_b);
  assign w_in_pad  = in_span(pixel_x, PAD_X_L, PAD_X_R) &&
                     in_span(pixel_y, w_paddle_y, w_paddle_y + C_PH1);
  assign w_in_wall = in_span(pixel_x, WALL_X_L, WALL_X_R) && (pixel_y <= SCREEN_Y_MAX);

  always_comb begin
    w_color = COLOR_OFF;
    if (!video_on)      w_color = COLOR_OFF;
    else if (w_in_ball) w_color = COLOR_BALL;
    else if (w_in_pad)  w_color = COLOR_PADDLE;
    else if (w_in_wall) w_color = COLOR_WALL;
  end

  // Colour and syncs share one register stage so they stay pixel-aligned.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rgb   <= COLOR_OFF;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (pixel_tick) begin
      r_rgb   <= w_color;
      r_hsync <= hsync_in;
      r_vsync <= vsync_in;
    end
  end

  assign rgb       = r_rgb;
  assign hsync_out = r_hsync;
  assign vsync_out = r_vsync;
  assign hit       = r_hit;
  assign miss      = r_miss;

endmodule

// File: tb/tb_pong_graphics_engine.sv
// Scoreboard bench: stimulus tasks queue the expected pixel-pipe output,
// a monitor pops and compares one clock after each registered pixel.
module tb_pong_graphics_engine;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_MISS = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pixel_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_start = 1'b0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, hit, miss;

  pong_graphics_engine dut (
    .clock     (clock),
    .reset     (reset),
    .pixel_tick(pixel_tick),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_start (btn_start),
    .rgb       (rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .hit       (hit),
    .miss      (miss)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] val;   // {rgb, hsync_out, vsync_out, hit, miss}
  } sb_t;

  sb_t sb_q[$];
  int  n_total = 0;
  int  n_bad   = 0;

  // Reference game state
  logic [1:0] m_st;
  int         m_bx, m_by, m_py, m_cnt;
  logic       m_dxn, m_dyn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_bx = 320; m_by = 240; m_dxn = 1'b1; m_dyn = 1'b0;
    m_py = 204; m_cnt = 0;
  endtask

  task automatic model_frame(input logic bu, input logic bd, input logic bs,
                             output logic e_hit, output logic e_miss);
    e_hit = 1'b0;
    e_miss = 1'b0;
    case (m_st)
      S_IDLE: if (bs) m_st = S_PLAY;
      S_PLAY: begin
        if (m_bx >= 632) begin
          e_miss = 1'b1; m_st = S_MISS; m_cnt = 0;
        end else begin
          if (m_by <= 2) m_dyn = 1'b0;
          else if (m_by + 7 >= 477) m_dyn = 1'b1;
          if (m_bx <= 37) m_dxn = 1'b0;
          else if (m_bx + 7 >= 600 && m_bx + 7 <= 603 && m_by + 7 >= m_py && m_by <= m_py + 71) begin
            m_dxn = 1'b1; e_hit = 1'b1;
          end
          m_bx = m_dxn ? m_bx - 2 : m_bx + 2;
          m_by = m_dyn ? m_by - 2 : m_by + 2;
        end
      end
      default: begin
        if (m_cnt == 59) begin
          m_st = S_IDLE; m_bx = 320; m_by = 240; m_dxn = 1'b1; m_cnt = 0;
        end else m_cnt++;
      end
    endcase
    if (bu && !bd) m_py = (m_py >= 4) ? m_py - 4 : 0;
    else if (bd && !bu) m_py = (m_py + 75 <= 479) ? m_py + 4 : 408;
  endtask

  function automatic logic [11:0] exp_rgb(input int x, input int y);
    if (m_st != S_MISS && x >= m_bx && x <= m_bx + 7 && y >= m_by && y <= m_by + 7) return 12'hF00;
    if (x >= 600 && x <= 603 && y >= m_py && y <= m_py + 71) return 12'h0F0;
    if (x >= 32 && x <= 35 && y <= 479) return 12'h00F;
    return 12'h000;
  endfunction

  // Row of the ball when it reaches x=594 while travelling right.
  function automatic int predict_y(input int bx, input int by, input logic dyn);
    int   x = bx;
    int   y = by;
    logic n = dyn;
    while (x < 594) begin
      if (y <= 2) n = 1'b0;
      else if (y + 7 >= 477) n = 1'b1;
      y = n ? y - 2 : y + 2;
      x += 2;
    end
    return y;
  endfunction

  task automatic pix(input string tag, input int x, input int y, input logic von,
                     input logic hs, input logic vs, input logic [11:0] e_rgb);
    @(posedge clock); #1;
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
    hsync_in = hs; vsync_in = vs; pixel_tick = 1'b1;
    sb_q.push_back('{tag, {e_rgb, hs, vs, 2'b00}});
    @(posedge clock); #1 pixel_tick = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic pix_m(input string tag, input int x, input int y);
    pix(tag, x, y, 1'b1, 1'b1, 1'b1, exp_rgb(x, y));
  endtask

  task automatic frame_step(output logic e_hit);
    logic e_miss;
    @(posedge clock); #1;
    pixel_x = '0; pixel_y = 10'd481; video_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; pixel_tick = 1'b1;
    model_frame(btn_up, btn_down, btn_start, e_hit, e_miss);
    sb_q.push_back('{"frame", {12'h000, 1'b1, 1'b1, e_hit, e_miss}});
    @(posedge clock); #1 pixel_tick = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic frames(input int n);
    logic h;
    for (int i = 0; i < n; i++) frame_step(h);
  endtask

  // Reset held 3 clocks across a frame_tick with btn_start high: reset must win.
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b1;
    pixel_x = '0; pixel_y = 10'd481; video_on = 1'b0; pixel_tick = 1'b1;
    sb_q.push_back('{"reset_tick", {12'h000, 1'b1, 1'b1, 2'b00}});
    @(posedge clock); #1 pixel_tick = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_out", {rgb, hsync_out, vsync_out, hit, miss}, {12'h000, 4'b1100});
    reset = 1'b1; btn_start = 1'b0;
    model_reset();
  endtask

  // Monitor: compare one clock after each registered pixel; otherwise pulses must be low.
  initial begin
    logic prev_tick;
    sb_t  e;
    prev_tick = 1'b0;
    forever begin
      @(negedge clock);
      if (prev_tick) begin
        if (sb_q.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL sb_empty: got output %h with no expectation",
                   {rgb, hsync_out, vsync_out, hit, miss});
        end else begin
          e = sb_q.pop_front();
          check(e.tag, {16'h0, rgb, hsync_out, vsync_out, hit, miss}, {16'h0, e.val});
        end
      end else begin
        check("pulse_low", {30'h0, hit, miss}, 32'h0);
      end
      prev_tick = pixel_tick;
    end
  end

  initial begin
    repeat (90000) @(posedge clock);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    logic fled;
    int   tgt, p;

    do_reset();

    // Reset picture: parked ball, paddle at 204, wall, blanking
    pix("ball_tl",   320, 240, 1'b1, 1'b1, 1'b1, 12'hF00);
    pix("ball_br",   327, 247, 1'b1, 1'b1, 1'b1, 12'hF00);
    pix("ball_rx",   328, 247, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("ball_by",   320, 248, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("ball_lx",   319, 240, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("ball_blank",320, 240, 1'b0, 1'b1, 1'b1, 12'h000);
    pix("wall",       33, 100, 1'b1, 1'b1, 1'b1, 12'h00F);
    pix("wall_bot",   33, 479, 1'b1, 1'b1, 1'b1, 12'h00F);
    pix("wall_below", 33, 480, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("wall_rx",    36, 100, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("pad_top",   601, 204, 1'b1, 1'b1, 1'b1, 12'h0F0);
    pix("pad_bot",   601, 275, 1'b1, 1'b1, 1'b1, 12'h0F0);
    pix("pad_below", 601, 276, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("pad_above", 601, 203, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("blank",     700,  10, 1'b0, 1'b1, 1'b1, 12'h000);

    // Sync pass-through alongside colour
    pix("sync_h", 320, 240, 1'b1, 1'b0, 1'b1, 12'hF00);
    pix("sync_v",  10,  10, 1'b1, 1'b1, 1'b0, 12'h000);
    pix("sync_hv", 10,  11, 1'b0, 1'b0, 1'b0, 12'h000);

    // Paddle clamps: down to 408, both buttons hold, up to 0, back to 204
    btn_down = 1'b1; frames(55);
    pix("pad_dn_top", 601, 408, 1'b1, 1'b1, 1'b1, 12'h0F0);
    pix("pad_dn_abv", 601, 407, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("pad_dn_bot", 601, 479, 1'b1, 1'b1, 1'b1, 12'h0F0);
    btn_up = 1'b1; frames(3);
    pix("pad_both",   601, 408, 1'b1, 1'b1, 1'b1, 12'h0F0);
    pix("pad_both_a", 601, 407, 1'b1, 1'b1, 1'b1, 12'h000);
    btn_down = 1'b0; frames(110);
    pix("pad_up_top", 601,   0, 1'b1, 1'b1, 1'b1, 12'h0F0);
    pix("pad_up_bot", 601,  71, 1'b1, 1'b1, 1'b1, 12'h0F0);
    pix("pad_up_blw", 601,  72, 1'b1, 1'b1, 1'b1, 12'h000);
    btn_up = 1'b0; btn_down = 1'b1; frames(51); btn_down = 1'b0;
    pix("pad_back",   601, 204, 1'b1, 1'b1, 1'b1, 12'h0F0);
    pix("pad_back_a", 601, 203, 1'b1, 1'b1, 1'b1, 12'h000);

    // btn_start away from frame_tick is ignored
    btn_start = 1'b1; pix_m("start_mid", 100, 100); btn_start = 1'b0;
    frames(1);
    pix("idle_park",  320, 240, 1'b1, 1'b1, 1'b1, 12'hF00);
    pix("idle_nomv",  318, 242, 1'b1, 1'b1, 1'b1, 12'h000);

    // Serve: no movement on the start frame, then (318,242)
    btn_start = 1'b1; frames(1); btn_start = 1'b0;
    pix("serve_park", 320, 240, 1'b1, 1'b1, 1'b1, 12'hF00);
    frames(1);
    pix("play_tl",    318, 242, 1'b1, 1'b1, 1'b1, 12'hF00);
    pix("play_lx",    317, 242, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("play_br",    325, 249, 1'b1, 1'b1, 1'b1, 12'hF00);
    pix("play_rx",    326, 249, 1'b1, 1'b1, 1'b1, 12'h000);
    pix("play_ay",    318, 241, 1'b1, 1'b1, 1'b1, 12'h000);

    // Rally: paddle meets the ball once, then steps aside so the ball is missed
    fled = 1'b0;
    for (int f = 0; f < 2000 && m_st == S_PLAY; f++) begin
      btn_up = 1'b0; btn_down = 1'b0;
      if (!m_dxn) begin
        p = predict_y(m_bx, m_by, m_dyn);
        if (!fled) begin
          tgt = p - 32;
          if (tgt < 0) tgt = 0;
          if (tgt > 408) tgt = 408;
        end else begin
          tgt = (p >= 200) ? 0 : 408;
        end
        btn_up   = (m_py >= tgt + 4);
        btn_down = (m_py + 4 <= tgt);
      end
      frame_step(h);
      if (h) fled = 1'b1;
      pix_m("rally_ball", m_bx, m_by);
      pix_m("rally_edge", m_bx + 8, m_by);
      pix_m("rally_pad", 601, m_py);
    end
    btn_up = 1'b0; btn_down = 1'b0;

    // MISS: ball hidden for 60 frames, btn_start ignored, then parked in IDLE
    pix("miss_hidden", m_bx, m_by, 1'b1, 1'b1, 1'b1, 12'h000);
    btn_start = 1'b1;
    for (int f = 0; f < 59; f++) begin
      frame_step(h);
      pix_m("miss_hold", m_bx, m_by);
    end
    pix("miss_last", m_bx, m_by, 1'b1, 1'b1, 1'b1, 12'h000);
    frames(1);
    btn_start = 1'b0;
    pix("reidle_tl", 320, 240, 1'b1, 1'b1, 1'b1, 12'hF00);
    pix("reidle_br", 327, 247, 1'b1, 1'b1, 1'b1, 12'hF00);

    // Second serve, then reset mid-game
    btn_start = 1'b1; frames(1); btn_start = 1'b0;
    for (int f = 0; f < 10; f++) begin
      frame_step(h);
      pix_m("game2_ball", m_bx, m_by);
    end
    pix("pre_reset", m_bx, m_by, 1'b1, 1'b0, 1'b0, 12'hF00);
    do_reset();
    pix("rst_park",   320, 240, 1'b1, 1'b1, 1'b1, 12'hF00);
    pix("rst_pad",    601, 204, 1'b1, 1'b1, 1'b1, 12'h0F0);
    pix("rst_pad_a",  601, 203, 1'b1, 1'b1, 1'b1, 12'h000);
    frames(1);
    pix("rst_idle",   320, 240, 1'b1, 1'b1, 1'b1, 12'hF00);
    pix("rst_nomv",   318, 242, 1'b1, 1'b1, 1'b1, 12'h000);

    repeat (8) @(posedge clock);
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
